regfile_mp: RTL and testbench

Parametrised multi-port register file for the next core generation. It provides NUM_RD combinational read ports with write-to-read bypass and NUM_WR write ports with fixed priority. A hardware clear sequencer zeroes every entry after reset or on request. It sits between decode (read) and writeback (write), replacing the 2R1W file.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 57 +++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// clear-sequencer state encoding.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int NUM_WR_DEF = 2;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on i_clear.
//
// state    | meaning
// ST_IDLE  | file usable, no sweep running
// ST_CLEAR | writing zero to entry[idx], one entry per cycle; file busy
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   output logic              o_busy,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_idx
);

   logic              state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Index wraps back to zero on its own as the last entry is written.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == ST_IDLE) begin
         if (i_clear) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
         end
      end else begin
         if (i_clear) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) state_d = ST_IDLE;
         end
      end
   end

   always_comb begin
      o_busy    = (state_q == ST_CLEAR);
      o_clr_we  = (state_q == ST_CLEAR);
      o_clr_idx = idx_q;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with write bypass,
// NUM_WR prioritised write ports. Optional feature macro: REGFILE_SCOREBOARD_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NUM_RD  = NUM_RD_DEF,
   parameter int NUM_WR  = NUM_WR_DEF,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic [NUM_RD-1:0]        i_rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rd_data,
   input  logic [NUM_WR-1:0]        i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
   output logic                     o_busy
`ifdef REGFILE_SCOREBOARD_EN
   ,
   input  logic                     i_alloc_en,
   input  logic [ADDR_W-1:0]        i_alloc_addr,
   output logic [NUM_RD-1:0]        o_rd_ready
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;

   logic [ADDR_W-1:0] rd_addr [NUM_RD];
   logic [ADDR_W-1:0] wr_addr [NUM_WR];
   logic [DATA_W-1:0] wr_data [NUM_WR];
   logic [NUM_WR-1:0] wr_commit;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (i_clear),
      .o_busy    (o_busy),
      .o_clr_we  (clr_we),
      .o_clr_idx (clr_idx)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
      assign rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
   end

   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
      assign wr_addr[j]   = i_wr_addr[j*ADDR_W +: ADDR_W];
      assign wr_data[j]   = i_wr_data[j*DATA_W +: DATA_W];
      assign wr_commit[j] = i_wr_en[j] && !o_busy && !(R0_ZERO && wr_addr[j] == '0);
   end

   // Ascending loop: the higher write port overwrites on an address collision.
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_idx] = '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_commit[j]) mem_d[wr_addr[j]] = wr_data[j];
         end
      end
   end

   // Storage is not reset; the clear sweep zeroes it after every reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      o_rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (!o_busy && i_rd_en[k] && !(R0_ZERO && rd_addr[k] == '0)) begin
            o_rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k]];
            for (int j = 0; j < NUM_WR; j++) begin
               if (i_wr_en[j] && wr_addr[j] == rd_addr[k])
                  o_rd_data[k*DATA_W +: DATA_W] = wr_data[j];
            end
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0]  pending_q, pending_d;
   logic [NUM_RD-1:0] byp_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   // Holding the vector at zero for the whole sweep matches clearing it on the
   // first sweep cycle, since allocations are ignored while busy anyway.
   always_comb begin
      pending_d = pending_q;
      if (o_busy) begin
         pending_d = '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_commit[j]) pending_d[wr_addr[j]] = 1'b0;
         end
         if (i_alloc_en && !(R0_ZERO && i_alloc_addr == '0))
            pending_d[i_alloc_addr] = 1'b1;
      end
   end

   always_comb begin
      byp_hit    = '0;
      o_rd_ready = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && wr_addr[j] == rd_addr[k]) byp_hit[k] = 1'b1;
         end
         if (o_busy)          o_rd_ready[k] = 1'b0;
         else if (!i_rd_en[k]) o_rd_ready[k] = 1'b1;
         else                 o_rd_ready[k] = !pending_q[rd_addr[k]] || byp_hit[k];
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver computes expected outputs from an
// abstract model and queues them; a negedge monitor compares against the DUT.
`timescale 1ns/1ps
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int DEPTH  = 32;

   typedef struct {
      logic                     busy;
      logic [NUM_RD*DATA_W-1:0] data;
      logic [NUM_RD-1:0]        ready;
      logic [NUM_RD-1:0]        rmask;
      int                       cyc;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     i_clear;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     busy;
`ifdef REGFILE_SCOREBOARD_EN
   logic                     al_en;
   logic [ADDR_W-1:0]        al_addr;
   logic [NUM_RD-1:0]        rd_ready;
`endif

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;

   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_pend [DEPTH];
   int                m_busy_left;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .R0_ZERO(1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (i_clear),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_busy    (busy)
`ifdef REGFILE_SCOREBOARD_EN
      ,
      .i_alloc_en   (al_en),
      .i_alloc_addr (al_addr),
      .o_rd_ready   (rd_ready)
`endif
   );

   task automatic set_idle();
      i_clear = 1'b0;
      rd_en   = '0;
      rd_addr = '0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
      al_en   = 1'b0;
      al_addr = '0;
`endif
   endtask

   task automatic set_rd(input int k, input logic en, input logic [ADDR_W-1:0] a);
      rd_en[k] = en;
      rd_addr[k*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic set_wr(input int j, input logic en, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      wr_en[j] = en;
      wr_addr[j*ADDR_W +: ADDR_W] = a;
      wr_data[j*DATA_W +: DATA_W] = d;
   endtask

   task automatic model_sweep();
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Inputs are already applied; predict this cycle's outputs, then advance the model.
   task automatic step();
      exp_t              e;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      bit                hit;
      e.busy  = !rst_n || (m_busy_left > 0);
      e.data  = '0;
      e.ready = '0;
      e.rmask = '0;
      e.cyc   = cyc;
      for (int k = 0; k < NUM_RD; k++) begin
         a = rd_addr[k*ADDR_W +: ADDR_W];
         if (!e.busy) begin
            e.rmask[k] = 1'b1;
            if (rd_en[k] && a != 0) begin
               hit = 0;
               d   = m_mem[a];
               for (int j = 0; j < NUM_WR; j++) begin
                  if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) begin
                     hit = 1;
                     d   = wr_data[j*DATA_W +: DATA_W];
                  end
               end
               e.data[k*DATA_W +: DATA_W] = d;
               e.ready[k] = !m_pend[a] || hit;
            end else begin
               e.ready[k] = 1'b1;
            end
         end else if (rd_en[k]) begin
            e.rmask[k] = 1'b1;
            e.ready[k] = 1'b0;
         end
      end
      exp_q.push_back(e);

      if (!rst_n || i_clear) begin
         model_sweep();
      end else if (m_busy_left > 0) begin
         m_busy_left--;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            a = wr_addr[j*ADDR_W +: ADDR_W];
            if (wr_en[j] && a != 0) begin
               m_mem[a]  = wr_data[j*DATA_W +: DATA_W];
               m_pend[a] = 1'b0;
            end
         end
`ifdef REGFILE_SCOREBOARD_EN
         if (al_en && al_addr != 0) m_pend[al_addr] = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (busy === e.busy) n_pass++;
         else $display("FAIL busy cyc=%0d got=%b want=%b", e.cyc, busy, e.busy);
         for (int k = 0; k < NUM_RD; k++) begin
            n_checks++;
            if (rd_data[k*DATA_W +: DATA_W] === e.data[k*DATA_W +: DATA_W]) n_pass++;
            else $display("FAIL rd_data[%0d] cyc=%0d got=%h want=%h", k, e.cyc,
                          rd_data[k*DATA_W +: DATA_W], e.data[k*DATA_W +: DATA_W]);
`ifdef REGFILE_SCOREBOARD_EN
            if (e.rmask[k]) begin
               n_checks++;
               if (rd_ready[k] === e.ready[k]) n_pass++;
               else $display("FAIL rd_ready[%0d] cyc=%0d got=%b want=%b", k, e.cyc,
                             rd_ready[k], e.ready[k]);
            end
`endif
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      set_idle();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_busy_left = DEPTH;
      @(posedge clk);
      #1;

      // Reset for 3 cycles, then the post-reset sweep
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      idle_cycles(DEPTH + 2);

      // Basic write / read
      set_idle(); set_wr(0, 1, 5'd5, 32'hDEADBEEF); step();
      set_idle(); set_rd(0, 1, 5'd5); set_rd(1, 1, 5'd5); step();
      set_idle(); set_rd(0, 1, 5'd0); set_rd(1, 1, 5'd5); step();

      // Same-address collision with same-cycle bypass read
      set_idle();
      set_wr(0, 1, 5'd7, 32'h11111111); set_wr(1, 1, 5'd7, 32'h22222222);
      set_rd(0, 1, 5'd7); step();
      set_idle(); set_rd(1, 1, 5'd7); step();

      // Writes to r0 dropped; disabled read returns zero
      set_idle(); set_wr(0, 1, 5'd0, 32'hCAFEF00D); set_rd(1, 1, 5'd0); step();
      set_idle(); set_rd(0, 1, 5'd0); step();
      set_idle(); set_wr(1, 1, 5'd9, 32'h99999999); set_rd(0, 0, 5'd9); step();
      set_idle(); set_rd(0, 1, 5'd9); step();

      // i_clear at sweep cycle 10 restarts; write to r3 during the sweep is dropped
      set_idle(); i_clear = 1'b1; step();
      idle_cycles(10);
      set_idle(); i_clear = 1'b1; set_wr(0, 1, 5'd3, 32'h33333333); step();
      set_idle(); set_wr(1, 1, 5'd3, 32'h44444444); step();
      idle_cycles(DEPTH);
      set_idle(); set_rd(0, 1, 5'd3); set_rd(1, 1, 5'd7); step();

      // Reset pulse at sweep index 20
      set_idle(); i_clear = 1'b1; step();
      idle_cycles(20);
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      idle_cycles(DEPTH + 1);

      // Entries written before a reset read back as zero afterwards
      for (int a = 1; a < DEPTH; a++) begin
         set_idle(); set_wr(0, 1, 5'(a), $urandom); step();
      end
      rst_n = 1'b0; set_idle(); step(); step();
      rst_n = 1'b1;
      idle_cycles(DEPTH);
      for (int a = 1; a < DEPTH; a += 2) begin
         set_idle(); set_rd(0, 1, 5'(a)); set_rd(1, 1, 5'(a + 1)); step();
      end

`ifdef REGFILE_SCOREBOARD_EN
      set_idle(); al_en = 1'b1; al_addr = 5'd4; step();
      set_idle(); set_rd(0, 1, 5'd4); step();
      set_idle(); set_rd(0, 1, 5'd4); set_wr(0, 1, 5'd4, 32'h5); step();
      set_idle(); set_rd(0, 1, 5'd4); step();
      set_idle(); al_en = 1'b1; al_addr = 5'd4; set_wr(1, 1, 5'd4, 32'h6); step();
      set_idle(); set_rd(1, 1, 5'd4); step();
`endif

      // Randomised traffic, biased to a few addresses for collisions and bypass hits
      for (int i = 0; i < 1500; i++) begin
         set_idle();
         i_clear = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < NUM_RD; k++)
            set_rd(k, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
         for (int j = 0; j < NUM_WR; j++)
            set_wr(j, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
`ifdef REGFILE_SCOREBOARD_EN
         al_en   = ($urandom_range(0, 2) == 0);
         al_addr = 5'($urandom_range(0, 7));
`endif
         step();
      end

      set_idle();
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
